// File: rtl/tick_timer.sv
// Periodic tick prescaler plus a loadable down-counter in tick units with a one-cycle expiry pulse.
// Define TICK_TIMER_AUTORELOAD_EN to reload the counter on expiry and keep running.
module tick_timer #(
  parameter int PRESCALE = 20,
  parameter int TIMER_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               cancel_i,
  output logic               tick_o,
  output logic               busy_o,
  output logic               expired_o,
  output logic [TIMER_W-1:0] count_o
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [TIMER_W-1:0] count_q, count_d;
  logic               expired_q, expired_d;
`ifdef TICK_TIMER_AUTORELOAD_EN
  logic [TIMER_W-1:0] reload_q, reload_d;
`endif

  assign tick_o    = (pre_q == PRE_W'(PRESCALE - 1));
  assign busy_o    = (state_q == RUN);
  assign expired_o = expired_q;
  assign count_o   = count_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    pre_d     = tick_o ? '0 : pre_q + PRE_W'(1);
`ifdef TICK_TIMER_AUTORELOAD_EN
    reload_d  = reload_q;
`endif

    if (cancel_i) begin
      state_d = IDLE;
      count_d = '0;
`ifdef TICK_TIMER_AUTORELOAD_EN
      reload_d = '0;
`endif
    end else if (start_i) begin
`ifdef TICK_TIMER_AUTORELOAD_EN
      reload_d = load_val_i;
`endif
      if (load_val_i != '0) begin
        state_d = RUN;
        count_d = load_val_i;
        pre_d   = '0;
      end else begin
        // A zero timeout expires immediately without entering RUN.
        state_d   = IDLE;
        count_d   = '0;
        expired_d = 1'b1;
      end
    end else if (state_q == RUN && tick_o) begin
      if (count_q <= TIMER_W'(1)) begin
        expired_d = 1'b1;
`ifdef TICK_TIMER_AUTORELOAD_EN
        count_d = reload_q;
`else
        state_d = IDLE;
        count_d = '0;
`endif
      end else begin
        count_d = count_q - TIMER_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
`ifdef TICK_TIMER_AUTORELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      count_q   <= count_d;
      expired_q <= expired_d;
`ifdef TICK_TIMER_AUTORELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

endmodule
